native_bus_initiator: RTL and testbench

- Data-side initiator for the native valid/ready memory bus. It drives the raddr/rdata/waddr/wdata channels toward a native memory responder.
- It accepts one load/store request at a time from the core's execute stage and sizes the access as byte, half or word.
- Loads are sign- or zero-extended. Sub-word stores are done as read-modify-write, because the bus has no byte strobes.
- It returns a single response (data or error) to the core.

---
 rtl/native_bus_initiator_pkg.sv | 30 +++
 rtl/native_bus_lane_align.sv | 36 +++
 rtl/native_bus_initiator.sv | 155 +++++++++++++++
 tb/tb_native_bus_initiator.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/native_bus_initiator_pkg.sv
// Shared encodings for the native bus initiator: access sizes, FSM states
// and the alignment rule used when a core request is accepted.
package native_bus_initiator_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: req_legal = 1'b1;
      SIZE_HALF: req_legal = ~offset[0];
      SIZE_WORD: req_legal = (offset == 2'b00);
      default:   req_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/native_bus_lane_align.sv
// Byte-lane steering: extracts and extends load data from a bus word, and
// merges sub-word store data into a previously read word.
module native_bus_lane_align
  import native_bus_initiator_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_lsb;
  logic [31:0] w_shifted;
  logic [31:0] w_mask;

  always_comb begin
    w_lsb     = {i_offset, 3'b000};
    w_shifted = i_rdata >> w_lsb;
    case (i_size)
      SIZE_BYTE: o_load = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
      SIZE_HALF: o_load = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
      default:   o_load = i_rdata;
    endcase
    // Half accesses are already known to be half-aligned, so w_lsb is 0 or 16.
    case (i_size)
      SIZE_BYTE: w_mask = 32'h0000_00FF << w_lsb;
      SIZE_HALF: w_mask = 32'h0000_FFFF << w_lsb;
      default:   w_mask = 32'hFFFF_FFFF;
    endcase
    o_merged = (i_rdata & ~w_mask) | ((i_wdata << w_lsb) & w_mask);
  end

endmodule

// File: rtl/native_bus_initiator.sv
// Data-side initiator: one load/store at a time from the core onto the native
// valid/ready memory bus, with read-modify-write for sub-word stores.
module native_bus_initiator
  import native_bus_initiator_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BUS_WIDTH-1:0] resp_data,
  output logic                 resp_error,
  output logic                 raddr_valid,
  input  logic                 raddr_ready,
  output logic [BUS_WIDTH-1:0] raddr,
  input  logic                 rdata_valid,
  output logic                 rdata_ready,
  input  logic [BUS_WIDTH-1:0] rdata,
  output logic                 waddr_valid,
  input  logic                 waddr_ready,
  output logic [BUS_WIDTH-1:0] waddr,
  output logic                 wdata_valid,
  input  logic                 wdata_ready,
  output logic [BUS_WIDTH-1:0] wdata
);

  state_e               r_state;
  state_e               w_next;
  logic [BUS_WIDTH-1:0] r_addr;
  logic [1:0]           r_size;
  logic                 r_write;
  logic                 r_unsigned;
  logic [BUS_WIDTH-1:0] r_wdata;
  logic [BUS_WIDTH-1:0] r_resp_data;
  logic                 r_resp_error;
  logic                 r_aw_done;
  logic                 r_w_done;
  logic                 w_legal;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic [BUS_WIDTH-1:0] w_load;
  logic [BUS_WIDTH-1:0] w_merged;

  native_bus_lane_align u_align (
    .i_rdata    (rdata),
    .i_wdata    (r_wdata),
    .i_offset   (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  assign raddr      = {r_addr[BUS_WIDTH-1:2], 2'b00};
  assign waddr      = {r_addr[BUS_WIDTH-1:2], 2'b00};
  assign wdata      = r_wdata;
  assign resp_data  = r_resp_data;
  assign resp_error = r_resp_error;

  always_comb begin
    req_ready   = 1'b0;
    raddr_valid = 1'b0;
    rdata_ready = 1'b0;
    waddr_valid = 1'b0;
    wdata_valid = 1'b0;
    resp_valid  = 1'b0;
    w_aw_hs     = 1'b0;
    w_w_hs      = 1'b0;
    w_next      = r_state;
    w_legal     = req_legal(req_size, req_addr[1:0]);
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!w_legal)                                w_next = ST_RESP;
          else if (req_write && req_size == SIZE_WORD) w_next = ST_WR;
          else                                         w_next = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        raddr_valid = 1'b1;
        if (raddr_ready) w_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        rdata_ready = 1'b1;
        if (rdata_valid) w_next = r_write ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        // Address and data channels retire independently.
        waddr_valid = ~r_aw_done;
        wdata_valid = ~r_w_done;
        w_aw_hs     = waddr_valid & waddr_ready;
        w_w_hs      = wdata_valid & wdata_ready;
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_size       <= 2'b00;
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_wdata      <= '0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr       <= req_addr;
            r_size       <= req_size;
            r_write      <= req_write;
            r_unsigned   <= req_unsigned;
            r_wdata      <= req_wdata;
            r_resp_data  <= '0;
            r_resp_error <= ~w_legal;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
          end
        end
        ST_RD_DATA: begin
          if (rdata_valid) begin
            if (r_write) r_wdata     <= w_merged;
            else         r_resp_data <= w_load;
          end
        end
        ST_WR: begin
          r_aw_done <= r_aw_done | w_aw_hs;
          r_w_done  <= r_w_done | w_w_hs;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_native_bus_initiator.sv
// Bench for native_bus_initiator: a byte-addressed reference memory model
// against a word-wide bus responder with directed and random stalls.
module tb_native_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_data;
  logic        raddr_valid, rdata_ready, waddr_valid, wdata_valid;
  logic        raddr_ready = 1'b0, rdata_valid = 1'b0, waddr_ready = 1'b0, wdata_ready = 1'b0;
  logic [31:0] raddr, waddr, wdata;
  logic [31:0] rdata = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:63];
  logic [7:0]  ref_mem [0:255];
  logic        mem_inited = 1'b0;
  bit          rand_mode = 1'b0;
  bit          rd_block  = 1'b0;
  int          aw_stall  = 0;

  logic        rd_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] rd_addr = 0, last_raddr = 0, last_waddr = 0, aw_q = 0, w_q = 0;
  int          n_rd = 0, n_wr = 0, cyc_rav = 0, cyc_wav = 0, cyc_wdv = 0, awv_run = 0;
  logic        hs_a, hs_w;
  logic [31:0] a_now, d_now;

  native_bus_initiator #(.BUS_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_error(resp_error),
    .raddr_valid(raddr_valid), .raddr_ready(raddr_ready), .raddr(raddr),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .waddr_valid(waddr_valid), .waddr_ready(waddr_ready), .waddr(waddr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata)
  );

  always #5 clk = ~clk;

  assign hs_a  = waddr_valid & waddr_ready;
  assign hs_w  = wdata_valid & wdata_ready;
  assign a_now = hs_a ? waddr : aw_q;
  assign d_now = hs_w ? wdata : w_q;

  // Responder bookkeeping at the active edge: handshakes and memory writes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (!mem_inited) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem_inited <= 1'b1;
      end
      rd_pend <= 1'b0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      awv_run <= 0;
    end else begin
      if (raddr_valid && raddr_ready) begin
        rd_pend    <= 1'b1;
        rd_addr    <= raddr;
        last_raddr <= raddr;
        n_rd       <= n_rd + 1;
      end
      if (rdata_valid && rdata_ready) rd_pend <= 1'b0;
      if (raddr_valid) cyc_rav <= cyc_rav + 1;
      if (waddr_valid) cyc_wav <= cyc_wav + 1;
      if (wdata_valid) cyc_wdv <= cyc_wdv + 1;
      awv_run <= (waddr_valid && !waddr_ready) ? awv_run + 1 : 0;
      if ((aw_got || hs_a) && (w_got || hs_w)) begin
        mem[a_now[7:2]] <= d_now;
        last_waddr      <= a_now;
        n_wr            <= n_wr + 1;
        aw_got          <= 1'b0;
        w_got           <= 1'b0;
      end else begin
        if (hs_a) begin aw_got <= 1'b1; aw_q <= waddr; end
        if (hs_w) begin w_got  <= 1'b1; w_q  <= wdata; end
      end
    end
  end

  // Responder drive on the inactive edge.
  always @(negedge clk) begin
    if (rand_mode) begin
      raddr_ready = 1'($urandom_range(0, 1));
      waddr_ready = 1'($urandom_range(0, 1));
      wdata_ready = 1'($urandom_range(0, 1));
    end else begin
      raddr_ready = 1'b1;
      wdata_ready = 1'b1;
      waddr_ready = (awv_run >= aw_stall);
    end
    if (rst && rd_pend && !rd_block && (!rand_mode || $urandom_range(0, 3) != 0)) begin
      rdata_valid = 1'b1;
      rdata       = mem[rd_addr[7:2]];
    end else begin
      rdata_valid = 1'b0;
      rdata       = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_legal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd0) || (sz == 2'd1 && a[0] == 1'b0) || (sz == 2'd2 && a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit u);
    logic [31:0] v;
    int nb;
    int base;
    nb   = nbytes(sz);
    base = int'(a[7:0]);
    v    = 32'h0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[(base + k) % 256];
    if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int base;
    base = int'({a[7:2], 2'b00});
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int base;
    base = int'(a[7:0]);
    for (int k = 0; k < nbytes(sz); k++) ref_mem[(base + k) % 256] = d[8*k +: 8];
  endtask

  // One request through to its response; lat counts cycles from accept edge.
  task automatic run_req(input bit w, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic re, output int lat);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1; lat++;
    end
    chk("resp_seen", {31'b0, resp_valid}, 32'd1);
    rd = resp_data;
    re = resp_error;
    if (rand_mode) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      chk("resp_hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("resp_hold_data", resp_data, rd);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        re;
    int          lat;
    int          b_rd, b_rav, b_wav, b_wdv;
    bit          w, u, lg;
    logic [1:0]  sz;
    logic [31:0] a, d;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",   {31'b0, req_ready},   32'd1);
    chk("rst_raddr_valid", {31'b0, raddr_valid}, 32'd0);
    chk("rst_rdata_ready", {31'b0, rdata_ready}, 32'd0);
    chk("rst_waddr_valid", {31'b0, waddr_valid}, 32'd0);
    chk("rst_wdata_valid", {31'b0, wdata_valid}, 32'd0);
    chk("rst_resp_valid",  {31'b0, resp_valid},  32'd0);
    chk("rst_resp_error",  {31'b0, resp_error},  32'd0);
    chk("rst_resp_data",   resp_data, 32'h0);
    chk("rst_raddr",       raddr, 32'h0);
    chk("rst_waddr",       waddr, 32'h0);
    chk("rst_wdata",       wdata, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Preload through full-word stores.
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h0201_7F80, rd, re, lat);
    ref_store(32'h10, 2'd2, 32'h0201_7F80);
    chk("sw_lat", lat, 2);
    chk("sw_err", {31'b0, re}, 32'd0);
    chk("sw_data", rd, 32'h0);
    chk("sw_mem", mem[4], 32'h0201_7F80);
    run_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, rd, re, lat);
    ref_store(32'h20, 2'd2, 32'h1122_3344);
    chk("sw2_mem", mem[8], 32'h1122_3344);

    b_rd = n_rd;
    run_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, rd, re, lat);
    chk("lb_data", rd, 32'hFFFF_FF80);
    chk("lb_err", {31'b0, re}, 32'd0);
    chk("lb_lat", lat, 3);
    chk("lb_raddr", last_raddr, 32'h10);
    chk("lb_reads", n_rd - b_rd, 1);
    chk("lb_next_ready", {31'b0, req_ready}, 32'd1);

    run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, re, lat);
    chk("lhu_data", rd, 32'h0000_0201);
    chk("lhu_raddr", last_raddr, 32'h10);

    b_rd = n_rd;
    run_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB, rd, re, lat);
    ref_store(32'h21, 2'd0, 32'h0000_00AB);
    chk("sb_reads", n_rd - b_rd, 1);
    chk("sb_raddr", last_raddr, 32'h20);
    chk("sb_waddr", last_waddr, 32'h20);
    chk("sb_mem", mem[8], 32'h1122_AB44);
    chk("sb_data", rd, 32'h0);
    chk("sb_lat", lat, 4);

    aw_stall = 3;
    b_wav = cyc_wav; b_wdv = cyc_wdv; b_rd = n_rd;
    run_req(1'b1, 2'd2, 1'b0, 32'h30, 32'hDEAD_BEEF, rd, re, lat);
    ref_store(32'h30, 2'd2, 32'hDEAD_BEEF);
    aw_stall = 0;
    chk("swst_wav_cycles", cyc_wav - b_wav, 4);
    chk("swst_wdv_cycles", cyc_wdv - b_wdv, 1);
    chk("swst_lat", lat, 5);
    chk("swst_reads", n_rd - b_rd, 0);
    chk("swst_mem", mem[12], 32'hDEAD_BEEF);

    b_rav = cyc_rav; b_wav = cyc_wav;
    run_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, rd, re, lat);
    chk("mis_err", {31'b0, re}, 32'd1);
    chk("mis_data", rd, 32'h0);
    chk("mis_lat", lat, 1);
    run_req(1'b1, 2'd3, 1'b0, 32'h0, 32'h5555_5555, rd, re, lat);
    chk("sz3_err", {31'b0, re}, 32'd1);
    chk("sz3_lat", lat, 1);
    chk("err_no_raddr", cyc_rav - b_rav, 0);
    chk("err_no_waddr", cyc_wav - b_wav, 0);

    // Reset while waiting for read data.
    rd_block = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rdata_ready", {31'b0, rdata_ready}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_raddr_valid", {31'b0, raddr_valid}, 32'd0);
    chk("arst_rdata_ready", {31'b0, rdata_ready}, 32'd0);
    chk("arst_resp_valid",  {31'b0, resp_valid},  32'd0);
    chk("arst_req_ready",   {31'b0, req_ready},   32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    rd_block = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, re, lat);
    chk("post_rst_data", rd, 32'h0201_7F80);
    chk("post_rst_lat", lat, 3);

    // Random traffic with random bus stalls.
    rand_mode = 1'b1;
    for (int t = 0; t < 80; t++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      d  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) a[1:0] = 2'b00;
        else if (sz == 2'd1) a[0] = 1'b0;
      end
      lg = ref_legal(sz, a);
      run_req(w, sz, u, a, d, rd, re, lat);
      chk("rnd_err", {31'b0, re}, {31'b0, !lg});
      if (!lg || w) chk("rnd_data_zero", rd, 32'h0);
      else          chk("rnd_load", rd, ref_load(a, sz, u));
      if (lg && w) begin
        ref_store(a, sz, d);
        chk("rnd_mem", mem[a[7:2]], ref_word(a));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
